// File: rtl/bj_pkg.sv
// Shared blackjack constants: card field positions, rank limits, scoring targets
// and the hand-accumulator state encoding.
package bj_pkg;

  localparam int RANK_LSB   = 0;
  localparam int RANK_MSB   = 3;
  localparam int SUIT_LSB   = 4;
  localparam int SUIT_MSB   = 5;

  localparam int RANK_ACE   = 1;
  localparam int RANK_KING  = 13;
  localparam int FACE_VALUE = 10;
  localparam int BJ_TARGET  = 21;
  localparam int ACE_BONUS  = 10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_WAIT   = 3'd2,
    ST_EVAL   = 3'd3,
    ST_DECIDE = 3'd4,
    ST_DONE   = 3'd5
  } bj_state_e;

endpackage

// File: rtl/bj_card_decode.sv
// Combinational card decoder: rank -> blackjack value (ace=1, faces=10),
// ace flag and rank validity. Suit and the top two bits carry no score.
module bj_card_decode
  import bj_pkg::*;
(
  input  logic [7:0] card_i,
  output logic [3:0] value_o,
  output logic       is_ace_o,
  output logic       rank_valid_o
);

  logic [3:0] rank;
  logic       unused_bits;

  assign rank        = card_i[RANK_MSB:RANK_LSB];
  assign unused_bits = ^{card_i[7:SUIT_MSB+1], card_i[SUIT_MSB:SUIT_LSB]};

  always_comb begin
    rank_valid_o = (rank >= 4'(RANK_ACE)) && (rank <= 4'(RANK_KING));
    is_ace_o     = (rank == 4'(RANK_ACE));
    value_o      = 4'd0;
    if (rank_valid_o) begin
      value_o = (rank > 4'(FACE_VALUE)) ? 4'(FACE_VALUE) : rank;
    end
  end

endmodule

// File: rtl/bj_hand_accumulator.sv
// Blackjack hand accumulator: requests cards, scores one hand with soft-ace
// handling, flags blackjack/bust. Define BJ_AUTO_DEALER_EN for dealer auto-draw.
module bj_hand_accumulator
  import bj_pkg::*;
#(
  parameter int MAX_CARDS    = 11,
  parameter int SCORE_W      = 5,
  parameter int DEALER_STAND = 17
) (
  input  logic               clk_ha_i,
  input  logic               rst_ha_i,
  input  logic               new_hand_i,
  input  logic [7:0]         card_i,
  input  logic               card_valid_i,
  input  logic               hit_i,
  input  logic               stand_i,
  output logic               req_card_o,
  output logic [SCORE_W-1:0] score_o,
  output logic [3:0]         card_cnt_o,
  output logic               soft_o,
  output logic               blackjack_o,
  output logic               bust_o,
  output logic               done_o,
  output logic               err_o,
  output logic [2:0]         state_dbg_o
);

  // Card handshake: req_card_o pulses for one cycle in REQ; the data path then
  // answers with card_valid_i, which is only consumed while in WAIT.
  bj_state_e          state_q, state_d;
  logic [SCORE_W-1:0] hard_q, hard_d, score_q, score_d;
  logic [3:0]         ace_q, ace_d, cnt_q, cnt_d, val_q, val_d;
  logic               is_ace_q, is_ace_d, soft_q, soft_d;
  logic               bj_q, bj_d, bust_q, bust_d, err_q, err_d;

  logic [3:0]         dec_value;
  logic               dec_is_ace, dec_valid;

  logic [SCORE_W-1:0] hard_n, score_n;
  logic [SCORE_W:0]   bonus_sum;
  logic [3:0]         ace_n, cnt_n;
  logic               soft_n;

  bj_card_decode u_decode (
    .card_i       (card_i),
    .value_o      (dec_value),
    .is_ace_o     (dec_is_ace),
    .rank_valid_o (dec_valid)
  );

  // Running totals including the card captured in WAIT; used only in EVAL.
  always_comb begin
    hard_n    = hard_q + SCORE_W'(val_q);
    ace_n     = ace_q + {3'b000, is_ace_q};
    cnt_n     = cnt_q + 4'd1;
    bonus_sum = {1'b0, hard_n} + (SCORE_W+1)'(ACE_BONUS);
    soft_n    = (ace_n != 4'd0) && (bonus_sum <= (SCORE_W+1)'(BJ_TARGET));
    score_n   = soft_n ? bonus_sum[SCORE_W-1:0] : hard_n;
  end

  always_ff @(posedge clk_ha_i) begin
    if (rst_ha_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

`ifdef BJ_AUTO_DEALER_EN
  logic unused_player;
  assign unused_player = hit_i ^ stand_i;
`else
  logic unused_cfg;
  assign unused_cfg = (DEALER_STAND == 0);
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (new_hand_i) state_d = ST_REQ;
      ST_REQ:    state_d = ST_WAIT;
      ST_WAIT:   if (card_valid_i) state_d = dec_valid ? ST_EVAL : ST_REQ;
      ST_EVAL: begin
        if (cnt_n < 4'd2)                                          state_d = ST_REQ;
        else if (score_n == SCORE_W'(BJ_TARGET) && cnt_n == 4'd2)  state_d = ST_DONE;
        else if (score_n > SCORE_W'(BJ_TARGET))                    state_d = ST_DONE;
        else if (cnt_n == 4'(MAX_CARDS))                           state_d = ST_DONE;
        else                                                       state_d = ST_DECIDE;
      end
      ST_DECIDE: begin
`ifdef BJ_AUTO_DEALER_EN
        state_d = (score_q < SCORE_W'(DEALER_STAND)) ? ST_REQ : ST_DONE;
`else
        if (stand_i)    state_d = ST_DONE;
        else if (hit_i) state_d = ST_REQ;
`endif
      end
      ST_DONE:   if (new_hand_i) state_d = ST_REQ;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_card_o = (state_q == ST_REQ);
    done_o     = (state_q == ST_DONE);
  end

  always_comb begin
    hard_d   = hard_q;
    score_d  = score_q;
    ace_d    = ace_q;
    cnt_d    = cnt_q;
    val_d    = val_q;
    is_ace_d = is_ace_q;
    soft_d   = soft_q;
    bj_d     = bj_q;
    bust_d   = bust_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (new_hand_i) begin
          hard_d   = '0;
          score_d  = '0;
          ace_d    = 4'd0;
          cnt_d    = 4'd0;
          val_d    = 4'd0;
          is_ace_d = 1'b0;
          soft_d   = 1'b0;
          bj_d     = 1'b0;
          bust_d   = 1'b0;
          err_d    = 1'b0;
        end
      end
      ST_WAIT: begin
        if (card_valid_i) begin
          if (dec_valid) begin
            val_d    = dec_value;
            is_ace_d = dec_is_ace;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_EVAL: begin
        hard_d  = hard_n;
        ace_d   = ace_n;
        cnt_d   = cnt_n;
        score_d = score_n;
        soft_d  = soft_n;
        bj_d    = (score_n == SCORE_W'(BJ_TARGET)) && (cnt_n == 4'd2);
        bust_d  = (score_n > SCORE_W'(BJ_TARGET));
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_ha_i) begin
    if (rst_ha_i) begin
      hard_q   <= '0;
      score_q  <= '0;
      ace_q    <= 4'd0;
      cnt_q    <= 4'd0;
      val_q    <= 4'd0;
      is_ace_q <= 1'b0;
      soft_q   <= 1'b0;
      bj_q     <= 1'b0;
      bust_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      hard_q   <= hard_d;
      score_q  <= score_d;
      ace_q    <= ace_d;
      cnt_q    <= cnt_d;
      val_q    <= val_d;
      is_ace_q <= is_ace_d;
      soft_q   <= soft_d;
      bj_q     <= bj_d;
      bust_q   <= bust_d;
      err_q    <= err_d;
    end
  end

  assign score_o     = score_q;
  assign card_cnt_o  = cnt_q;
  assign soft_o      = soft_q;
  assign blackjack_o = bj_q;
  assign bust_o      = bust_q;
  assign err_o       = err_q;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_bj_hand_accumulator.sv
// Self-checking bench for bj_hand_accumulator: directed hands plus random hands
// scored by a card-list reference model. Honors BJ_AUTO_DEALER_EN.
module tb_bj_hand_accumulator;
  import bj_pkg::*;

  localparam int MAX_CARDS    = 11;
  localparam int SCORE_W      = 5;
  localparam int DEALER_STAND = 17;

  logic               clk_ha_i;
  logic               rst_ha_i;
  logic               new_hand_i;
  logic [7:0]         card_i;
  logic               card_valid_i;
  logic               hit_i;
  logic               stand_i;
  logic               req_card_o;
  logic [SCORE_W-1:0] score_o;
  logic [3:0]         card_cnt_o;
  logic               soft_o;
  logic               blackjack_o;
  logic               bust_o;
  logic               done_o;
  logic               err_o;
  logic [2:0]         state_dbg_o;

  int checks  = 0;
  int errors  = 0;
  int req_cnt = 0;

  logic [7:0] deck_q[$];
  int         dec_q[$];

  bj_hand_accumulator #(
    .MAX_CARDS    (MAX_CARDS),
    .SCORE_W      (SCORE_W),
    .DEALER_STAND (DEALER_STAND)
  ) dut (
    .clk_ha_i     (clk_ha_i),
    .rst_ha_i     (rst_ha_i),
    .new_hand_i   (new_hand_i),
    .card_i       (card_i),
    .card_valid_i (card_valid_i),
    .hit_i        (hit_i),
    .stand_i      (stand_i),
    .req_card_o   (req_card_o),
    .score_o      (score_o),
    .card_cnt_o   (card_cnt_o),
    .soft_o       (soft_o),
    .blackjack_o  (blackjack_o),
    .bust_o       (bust_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .state_dbg_o  (state_dbg_o)
  );

  // Clock / reset
  initial clk_ha_i = 1'b0;
  always #5 clk_ha_i = ~clk_ha_i;

  task automatic tick();
    @(posedge clk_ha_i);
    #1;
    if (req_card_o) req_cnt++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference model: a hand is just the list of accepted card values
  function automatic int card_value(input int rank);
    return (rank >= 11) ? 10 : rank;
  endfunction

  function automatic void model_score(input int vals[$], output int sc, output int sf);
    int hard = 0;
    int aces = 0;
    foreach (vals[i]) begin
      hard += vals[i];
      if (vals[i] == 1) aces++;
    end
    if (aces > 0 && hard + 10 <= 21) begin
      sc = hard + 10;
      sf = 1;
    end else begin
      sc = hard;
      sf = 0;
    end
  endfunction

  function automatic logic [7:0] next_card();
    int r;
    int sel;
    if (deck_q.size() > 0) return deck_q.pop_front();
    if ($urandom_range(0, 7) == 0) begin
      sel = $urandom_range(0, 2);
      r   = (sel == 0) ? 0 : 13 + sel;
    end else begin
      r = $urandom_range(1, 13);
    end
    return {2'($urandom), 2'($urandom), 4'(r)};
  endfunction

  // 0 = stand, 1 = hit, 2 = hit and stand together
  function automatic int next_decision();
    int d;
    if (dec_q.size() > 0) return dec_q.pop_front();
    d = $urandom_range(0, 3);
    return (d == 0) ? 0 : (d == 3) ? 2 : 1;
  endfunction

  task automatic check_final(input string tag, input int sc, input int sf, input int cnt,
                             input int er, input int bj, input int bu);
    chk({tag, "/done"},  done_o,      1);
    chk({tag, "/score"}, score_o,     sc);
    chk({tag, "/soft"},  soft_o,      sf);
    chk({tag, "/cnt"},   card_cnt_o,  cnt);
    chk({tag, "/err"},   err_o,       er);
    chk({tag, "/bj"},    blackjack_o, bj);
    chk({tag, "/bust"},  bust_o,      bu);
  endtask

  // Driver: plays one hand from deck_q/dec_q (random when empty) and checks it
  task automatic run_hand(input string tag);
    int vals[$];
    int sc, sf, prev_sc, prev_sf, er, bj, bu, guard, d, cnt, r;
    bit fin;
    logic [7:0] c;
    vals = {};
    er = 0; bj = 0; bu = 0; sc = 0; sf = 0; fin = 0; guard = 0;
    new_hand_i = 1'b1;
    tick();
    new_hand_i = 1'b0;
    chk({tag, "/start_score"}, score_o, 0);
    chk({tag, "/start_err"},   err_o,   0);
    chk({tag, "/start_done"},  done_o,  0);
    while (!fin && guard < 60) begin
      guard++;
      chk({tag, "/req"}, req_card_o, 1);
      tick();
      repeat ($urandom_range(0, 2)) tick();
      c = next_card();
      card_i = c;
      card_valid_i = 1'b1;
      tick();
      card_valid_i = 1'b0;
      card_i = 8'($urandom);
      r = int'(c[3:0]);
      if (r == 0 || r > 13) begin
        er = 1;
        chk({tag, "/bad_err"}, err_o,      1);
        chk({tag, "/bad_cnt"}, card_cnt_o, vals.size());
        continue;
      end
      model_score(vals, prev_sc, prev_sf);
      chk({tag, "/latency"}, score_o, prev_sc);
      vals.push_back(card_value(r));
      tick();
      model_score(vals, sc, sf);
      cnt = vals.size();
      chk({tag, "/score"}, score_o,    sc);
      chk({tag, "/soft"},  soft_o,     sf);
      chk({tag, "/cnt"},   card_cnt_o, cnt);
      chk({tag, "/err"},   err_o,      er);
      if (cnt < 2) continue;
      if (sc == 21 && cnt == 2) begin
        bj = 1; fin = 1;
      end else if (sc > 21) begin
        bu = 1; fin = 1;
      end else if (cnt == MAX_CARDS) begin
        fin = 1;
      end else begin
        chk({tag, "/decide"}, state_dbg_o, ST_DECIDE);
        chk({tag, "/not_done"}, done_o, 0);
`ifdef BJ_AUTO_DEALER_EN
        tick();
        if (sc >= DEALER_STAND) fin = 1;
`else
        repeat ($urandom_range(0, 2)) begin
          card_valid_i = 1'b1;
          new_hand_i   = 1'b1;
          tick();
          card_valid_i = 1'b0;
          new_hand_i   = 1'b0;
          chk({tag, "/hold"}, state_dbg_o, ST_DECIDE);
          chk({tag, "/hold_cnt"}, card_cnt_o, cnt);
        end
        d = next_decision();
        hit_i   = (d != 0);
        stand_i = (d != 1);
        tick();
        hit_i   = 1'b0;
        stand_i = 1'b0;
        if (d != 1) fin = 1;
`endif
      end
    end
    chk({tag, "/finished"}, fin, 1);
    check_final(tag, sc, sf, vals.size(), er, bj, bu);
    repeat (3) begin
      hit_i        = 1'($urandom);
      stand_i      = 1'($urandom);
      card_valid_i = 1'b1;
      tick();
    end
    hit_i = 1'b0; stand_i = 1'b0; card_valid_i = 1'b0;
    check_final({tag, "_held"}, sc, sf, vals.size(), er, bj, bu);
  endtask

  task automatic deal(input logic [7:0] c);
    tick();
    card_i = c;
    card_valid_i = 1'b1;
    tick();
    card_valid_i = 1'b0;
  endtask

  initial begin
    rst_ha_i = 1'b1; new_hand_i = 1'b0; card_i = 8'h00;
    card_valid_i = 1'b0; hit_i = 1'b0; stand_i = 1'b0;
    repeat (3) tick();
    rst_ha_i = 1'b0;
    chk("rst/state", state_dbg_o, ST_IDLE);
    chk("rst/score", score_o, 0);
    chk("rst/cnt",   card_cnt_o, 0);
    chk("rst/flags", {req_card_o, soft_o, blackjack_o, bust_o, done_o, err_o}, 0);
    tick();
    chk("idle/hold", state_dbg_o, ST_IDLE);

    // Ace plus king: blackjack, exactly two requests
    deck_q = {8'h01, 8'h1D};
    req_cnt = 0;
    run_hand("bj");
    chk("bj/req_pulses", req_cnt, 2);

`ifdef BJ_AUTO_DEALER_EN
    deck_q = {8'h0A, 8'h05, 8'h02};
    req_cnt = 0;
    run_hand("dealer17");
    chk("dealer17/req_pulses", req_cnt, 3);
    deck_q = {8'h01, 8'h06};
    run_hand("dealer_soft17");
`else
    deck_q = {8'h0A, 8'h06, 8'h29};
    dec_q  = {1};
    run_hand("bust");
    deck_q = {8'h01, 8'h01, 8'h09};
    dec_q  = {1, 2};
    run_hand("soft21");
    deck_q = {8'h0E, 8'h05, 8'h03};
    dec_q  = {0};
    run_hand("badrank");
    deck_q = {8'h01, 8'h01, 8'h01, 8'h01, 8'h02, 8'h02, 8'h02, 8'h02, 8'h03, 8'h03, 8'h03};
    dec_q  = {1, 1, 1, 1, 1, 1, 1, 1, 1};
    run_hand("maxcards");
`endif

    for (int h = 0; h < 25; h++) begin
      run_hand($sformatf("rand%0d", h));
    end

    // Synchronous reset while sitting in DECIDE at 15
    new_hand_i = 1'b1;
    tick();
    new_hand_i = 1'b0;
    deal(8'h07);
    tick();
    deal(8'h08);
    tick();
    chk("midrst/score", score_o, 15);
    chk("midrst/decide", state_dbg_o, ST_DECIDE);
    rst_ha_i = 1'b1;
    tick();
    rst_ha_i = 1'b0;
    chk("midrst/state", state_dbg_o, ST_IDLE);
    chk("midrst/score0", score_o, 0);
    chk("midrst/cnt0", card_cnt_o, 0);
    chk("midrst/flags0", {req_card_o, soft_o, blackjack_o, bust_o, done_o, err_o}, 0);
    hit_i = 1'b1;
    tick();
    hit_i = 1'b0;
    chk("midrst/hit_ignored", state_dbg_o, ST_IDLE);
    chk("midrst/no_req", req_card_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
